// File: rtl/int_ctrl.sv
// Fixed-priority interrupt controller: masks level interrupt lines and presents
// the lowest-index eligible source to the CPU over a req/ack/done handshake.
module int_ctrl #(
  parameter int N_SRC = 4,
  parameter int VEC_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq_in,
  input  logic             cfg_we,
  input  logic [N_SRC:0]   cfg_wdata,
  output logic             int_req,
  output logic [VEC_W-1:0] int_vec,
  input  logic             int_ack,
  input  logic             int_done,
  output logic [N_SRC-1:0] src_clr,
  output logic             in_service,
  output logic [N_SRC-1:0] pend,
  output logic [1:0]       dbg_state
);

  // Handshake: int_req is held with a stable int_vec until the cycle int_ack is
  // sampled high (transfer) or the requested source stops being eligible
  // (withdraw); ack wins a tie. int_done closes service and is only honoured in SERV.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SERV = 2'd2
  } state_t;

  state_t           state;
  logic [N_SRC-1:0] mask;
  logic             ie;
  logic [N_SRC-1:0] eligible;
  logic [N_SRC-1:0] vec_onehot;
  logic [VEC_W-1:0] first_idx;
  logic             any_eligible;
  logic             vec_eligible;

  always_comb begin
    eligible = irq_in & mask & {N_SRC{ie}};
    first_idx = '0;
    // Scan downwards so the lowest set index is the last one written.
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) first_idx = VEC_W'(i);
    end
    vec_onehot = '0;
    for (int i = 0; i < N_SRC; i++) begin
      vec_onehot[i] = (int_vec == VEC_W'(i));
    end
  end

  assign any_eligible = |eligible;
  assign vec_eligible = |(eligible & vec_onehot);
  assign dbg_state    = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      mask       <= '0;
      ie         <= 1'b0;
      int_req    <= 1'b0;
      int_vec    <= '0;
      src_clr    <= '0;
      in_service <= 1'b0;
      pend       <= '0;
    end else begin
      pend    <= irq_in & mask;
      src_clr <= '0;
      if (cfg_we) begin
        mask <= cfg_wdata[N_SRC-1:0];
        ie   <= cfg_wdata[N_SRC];
      end
      case (state)
        IDLE: begin
          if (any_eligible) begin
            int_vec <= first_idx;
            int_req <= 1'b1;
            state   <= REQ;
          end
        end
        REQ: begin
          if (int_ack) begin
            int_req    <= 1'b0;
            in_service <= 1'b1;
            src_clr    <= vec_onehot;
            state      <= SERV;
          end else if (!vec_eligible) begin
            int_req <= 1'b0;
            state   <= IDLE;
          end
        end
        SERV: begin
          if (int_done) begin
            in_service <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          int_req    <= 1'b0;
          in_service <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_int_ctrl.sv
// Bench for int_ctrl: directed scenarios followed by randomized CPU/source
// traffic, all checked against a cycle-level behavioural model.
module tb_int_ctrl;
  localparam int N_SRC = 4;
  localparam int VEC_W = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N_SRC-1:0] irq_in = '0;
  logic             cfg_we = 1'b0;
  logic [N_SRC:0]   cfg_wdata = '0;
  logic             int_req;
  logic [VEC_W-1:0] int_vec;
  logic             int_ack = 1'b0;
  logic             int_done = 1'b0;
  logic [N_SRC-1:0] src_clr;
  logic             in_service;
  logic [N_SRC-1:0] pend;
  logic [1:0]       dbg_state;

  int total = 0;
  int bad = 0;

  // Model state: what the CPU would see, tracked as plain flags.
  logic [N_SRC-1:0] m_mask, m_pend, m_clr;
  logic             m_ie, m_req, m_serv;
  logic [VEC_W-1:0] m_vec;

  int_ctrl #(.N_SRC(N_SRC), .VEC_W(VEC_W)) dut (
    .clk(clk), .rst(rst), .irq_in(irq_in), .cfg_we(cfg_we), .cfg_wdata(cfg_wdata),
    .int_req(int_req), .int_vec(int_vec), .int_ack(int_ack), .int_done(int_done),
    .src_clr(src_clr), .in_service(in_service), .pend(pend), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int lowest(input logic [N_SRC-1:0] v);
    for (int i = 0; i < N_SRC; i++) begin
      if (v[i]) return i;
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_mask = '0; m_ie = 1'b0; m_req = 1'b0; m_serv = 1'b0;
    m_vec = '0; m_clr = '0; m_pend = '0;
  endtask

  // Advance the model by one rising edge using the inputs currently applied.
  task automatic model_step();
    logic [N_SRC-1:0] elig;
    if (rst) begin
      model_reset();
      return;
    end
    elig   = irq_in & m_mask & {N_SRC{m_ie}};
    m_pend = irq_in & m_mask;
    m_clr  = '0;
    if (m_serv) begin
      if (int_done) m_serv = 1'b0;
    end else if (m_req) begin
      if (int_ack) begin
        m_req  = 1'b0;
        m_serv = 1'b1;
        m_clr  = N_SRC'(1) << m_vec;
      end else if (!elig[m_vec]) begin
        m_req = 1'b0;
      end
    end else if (elig != '0) begin
      m_vec = VEC_W'(lowest(elig));
      m_req = 1'b1;
    end
    if (cfg_we) begin
      m_mask = cfg_wdata[N_SRC-1:0];
      m_ie   = cfg_wdata[N_SRC];
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".int_req"}, 32'(int_req), 32'(m_req));
    check({tag, ".int_vec"}, 32'(int_vec), 32'(m_vec));
    check({tag, ".src_clr"}, 32'(src_clr), 32'(m_clr));
    check({tag, ".in_service"}, 32'(in_service), 32'(m_serv));
    check({tag, ".pend"}, 32'(pend), 32'(m_pend));
  endtask

  // One clock: model follows the edge, outputs are compared at the falling edge.
  task automatic step(input string tag);
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all(tag);
  endtask

  task automatic cfg_write(input logic [N_SRC:0] d, input string tag);
    cfg_we = 1'b1; cfg_wdata = d;
    step(tag);
    cfg_we = 1'b0;
  endtask

  // Called at a falling edge: assert reset mid-cycle and expect immediate effect.
  task automatic async_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    model_reset();
    compare_all(tag);
    int_ack = 1'b0; int_done = 1'b0; cfg_we = 1'b0;
    step({tag, ".hold"});
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    #12;
    compare_all("reset");
    rst = 1'b0;

    // Single source, full handshake.
    cfg_write(5'b1_0001, "t1.cfg");
    irq_in = 4'b0001;
    step("t1.req");
    check("t1.req_hi", 32'(int_req), 32'd1);
    check("t1.vec0", 32'(int_vec), 32'd0);
    int_ack = 1'b1;
    step("t1.ack");
    check("t1.clr", 32'(src_clr), 32'b0001);
    check("t1.insvc", 32'(in_service), 32'd1);
    int_ack = 1'b0; irq_in = 4'b0000;
    step("t1.serv");
    check("t1.clr_off", 32'(src_clr), 32'd0);
    int_done = 1'b1;
    step("t1.done");
    int_done = 1'b0;
    check("t1.idle", 32'(in_service), 32'd0);

    // Priority and back-to-back requests.
    cfg_write(5'b1_1111, "t2.cfg");
    irq_in = 4'b1010;
    step("t2.req");
    check("t2.vec1", 32'(int_vec), 32'd1);
    int_ack = 1'b1;
    step("t2.ack");
    int_ack = 1'b0; irq_in = 4'b1000;
    step("t2.serv");
    int_done = 1'b1;
    step("t2.done");
    int_done = 1'b0;
    check("t2.gap", 32'(int_req), 32'd0);
    step("t2.req2");
    check("t2.vec3", 32'(int_vec), 32'd3);
    check("t2.req2_hi", 32'(int_req), 32'd1);
    int_ack = 1'b1;
    step("t2.ack2");
    int_ack = 1'b0; irq_in = 4'b0000;
    int_done = 1'b1;
    step("t2.done2");
    int_done = 1'b0;

    // Withdraw, then drop and ack together.
    irq_in = 4'b0100;
    step("t3.req");
    check("t3.vec2", 32'(int_vec), 32'd2);
    irq_in = 4'b0000;
    step("t3.wd");
    check("t3.wd_req", 32'(int_req), 32'd0);
    check("t3.wd_clr", 32'(src_clr), 32'd0);
    step("t3.wd_idle");
    irq_in = 4'b0100;
    step("t3.req2");
    irq_in = 4'b0000; int_ack = 1'b1;
    step("t3.tie");
    check("t3.tie_clr", 32'(src_clr), 32'b0100);
    int_ack = 1'b0; int_done = 1'b1;
    step("t3.done");
    int_done = 1'b0;

    // Masking and global enable.
    cfg_write(5'b0_1111, "t4.ie0");
    irq_in = 4'b1111;
    for (int i = 0; i < 3; i++) step("t4.ie0_wait");
    check("t4.ie0_noreq", 32'(int_req), 32'd0);
    check("t4.ie0_pend", 32'(pend), 32'b1111);
    cfg_write(5'b1_0000, "t4.m0");
    step("t4.m0_wait");
    check("t4.m0_noreq", 32'(int_req), 32'd0);
    check("t4.m0_pend", 32'(pend), 32'd0);
    cfg_write(5'b1_0100, "t4.m2");
    step("t4.m2_req");
    check("t4.m2_vec", 32'(int_vec), 32'd2);
    check("t4.m2_req_hi", 32'(int_req), 32'd1);

    // No nesting: ack during service is ignored.
    int_ack = 1'b1;
    step("t5.ack");
    int_ack = 1'b0; irq_in = 4'b0001;
    cfg_write(5'b1_1111, "t5.cfg");
    int_ack = 1'b1;
    step("t5.ack_ign");
    check("t5.no_req", 32'(int_req), 32'd0);
    check("t5.no_clr", 32'(src_clr), 32'd0);
    int_ack = 1'b0; int_done = 1'b1;
    step("t5.done");
    int_done = 1'b0;
    step("t5.req");
    check("t5.vec0", 32'(int_vec), 32'd0);
    check("t5.req_hi", 32'(int_req), 32'd1);

    // Asynchronous reset mid-REQ and mid-SERV.
    async_reset("t6.arst_req");
    for (int i = 0; i < 3; i++) step("t6.unconf");
    check("t6.unconf_noreq", 32'(int_req), 32'd0);
    cfg_write(5'b1_0001, "t6.cfg");
    step("t6.req");
    int_ack = 1'b1;
    step("t6.ack");
    int_ack = 1'b0;
    check("t6.serv", 32'(in_service), 32'd1);
    async_reset("t6.arst_serv");
    irq_in = '0;

    // Randomized traffic.
    cfg_write(5'b1_1111, "rnd.cfg");
    for (int n = 0; n < 3000; n++) begin
      int_ack  = int_req && ($urandom_range(0, 2) == 0);
      int_done = ($urandom_range(0, 5) == 0);
      irq_in   = irq_in & ~m_clr;
      if ($urandom_range(0, 3) == 0) irq_in = irq_in | N_SRC'($urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) irq_in = irq_in & N_SRC'($urandom_range(0, 15));
      cfg_we = ($urandom_range(0, 24) == 0);
      cfg_wdata = {($urandom_range(0, 3) != 0), N_SRC'($urandom_range(0, 15))};
      if ($urandom_range(0, 599) == 0) async_reset("rnd.arst");
      else step("rnd");
    end
    int_ack = 1'b0; int_done = 1'b0; cfg_we = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
